// File: rtl/joypad_bridge.sv
// USB gamepad report bridge to NES $4016/$4017 serial joypad registers.
// Optional turbo A/B gating is enabled by defining JOYPAD_TURBO_EN.
module joypad_bridge #(
    parameter int          NUM_PADS       = 2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2400000,
    parameter bit          SOCD_FILTER    = 1'b1,
    parameter logic [15:0] TURBO_DIV      = 16'd50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*NUM_PADS-1:0] pad_data,
    input  logic [NUM_PADS-1:0]   pad_ena,
    input  logic                  cpu_strobe_wr,
    input  logic                  cpu_strobe_d,
    input  logic [NUM_PADS-1:0]   cpu_rd,
`ifdef JOYPAD_TURBO_EN
    input  logic [2*NUM_PADS-1:0] turbo_mask,
`endif
    output logic [NUM_PADS-1:0]   cpu_rd_data,
    output logic [8*NUM_PADS-1:0] pad_state,
    output logic [NUM_PADS-1:0]   pad_valid
);

    localparam bit          T_EN   = (TIMEOUT_CYCLES != 24'd0);
    localparam int          TW     = T_EN ? $clog2(32'(TIMEOUT_CYCLES) + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 24'd1);

    logic [7:0]    state    [NUM_PADS];
    logic [7:0]    shift    [NUM_PADS];
    logic [7:0]    load_val [NUM_PADS];
    logic [TW-1:0] tcnt     [NUM_PADS];
    logic [NUM_PADS-1:0] valid;
    logic          strobe;
    logic          load_now;

    function automatic logic [7:0] filt(input logic [7:0] d);
        logic [7:0] r;
        r = d;
        if (SOCD_FILTER) begin
            if (d[4] && d[5]) r[5:4] = 2'b00;
            if (d[6] && d[7]) r[7:6] = 2'b00;
        end
        return r;
    endfunction

`ifdef JOYPAD_TURBO_EN
    logic [15:0] turbo_cnt;
    logic        turbo_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            turbo_cnt   <= '0;
            turbo_phase <= 1'b0;
        end else if (turbo_cnt == TURBO_DIV - 16'd1) begin
            turbo_cnt   <= '0;
            turbo_phase <= ~turbo_phase;
        end else begin
            turbo_cnt <= turbo_cnt + 16'd1;
        end
    end

    // Turbo only gates what the CPU sees; held state stays clean for LEDs.
    always_comb begin
        for (int i = 0; i < NUM_PADS; i++) begin
            load_val[i] = state[i];
            if (!turbo_phase) begin
                if (turbo_mask[2*i])   load_val[i][0] = 1'b0;
                if (turbo_mask[2*i+1]) load_val[i][1] = 1'b0;
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_PADS; i++) load_val[i] = state[i];
    end
`endif

    // A write with d=1 reloads in the same cycle as the latch is set.
    assign load_now = strobe || (cpu_strobe_wr && cpu_strobe_d);

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe <= 1'b0;
            valid  <= '0;
            for (int i = 0; i < NUM_PADS; i++) begin
                state[i] <= '0;
                shift[i] <= '0;
                tcnt[i]  <= '0;
            end
        end else begin
            if (cpu_strobe_wr) strobe <= cpu_strobe_d;
            for (int i = 0; i < NUM_PADS; i++) begin
                if (pad_ena[i]) begin
                    state[i] <= filt(pad_data[8*i +: 8]);
                    valid[i] <= 1'b1;
                    tcnt[i]  <= '0;
                end else if (T_EN && valid[i]) begin
                    if (tcnt[i] == T_LAST) begin
                        state[i] <= '0;
                        valid[i] <= 1'b0;
                        tcnt[i]  <= '0;
                    end else if (tcnt[i] != '1) begin
                        tcnt[i] <= tcnt[i] + TW'(1);
                    end
                end

                // Ones shifted in make reads past the eighth return 1.
                if (load_now)
                    shift[i] <= load_val[i];
                else if (!cpu_strobe_wr && cpu_rd[i])
                    shift[i] <= {1'b1, shift[i][7:1]};
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PADS; i++) begin
            pad_state[8*i +: 8] = state[i];
            cpu_rd_data[i]      = shift[i][0];
        end
    end

    assign pad_valid = valid;

endmodule

// File: tb/tb_joypad_bridge.sv
// Directed self-checking bench for joypad_bridge: reset, serial reads,
// SOCD filtering, timeout, strobe reload, multi-port and optional turbo.
module tb_joypad_bridge;

    localparam int NP = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [8*NP-1:0] pad_data = '0;
    logic [NP-1:0] pad_ena = '0;
    logic          cpu_strobe_wr = 1'b0;
    logic          cpu_strobe_d = 1'b0;
    logic [NP-1:0] cpu_rd = '0;
    logic [2*NP-1:0] turbo_mask = '0;
    logic [NP-1:0] cpu_rd_data, nf_rd_data;
    logic [8*NP-1:0] pad_state, nf_state;
    logic [NP-1:0] pad_valid, nf_valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    joypad_bridge #(.NUM_PADS(NP), .TIMEOUT_CYCLES(24'd100), .SOCD_FILTER(1'b1),
                    .TURBO_DIV(16'd4)) dut (
        .clk(clk), .rst(rst), .pad_data(pad_data), .pad_ena(pad_ena),
        .cpu_strobe_wr(cpu_strobe_wr), .cpu_strobe_d(cpu_strobe_d), .cpu_rd(cpu_rd),
`ifdef JOYPAD_TURBO_EN
        .turbo_mask(turbo_mask),
`endif
        .cpu_rd_data(cpu_rd_data), .pad_state(pad_state), .pad_valid(pad_valid));

    // Unfiltered instance with the timeout disabled, fed the same stimulus.
    joypad_bridge #(.NUM_PADS(NP), .TIMEOUT_CYCLES(24'd0), .SOCD_FILTER(1'b0),
                    .TURBO_DIV(16'd4)) dut_nf (
        .clk(clk), .rst(rst), .pad_data(pad_data), .pad_ena(pad_ena),
        .cpu_strobe_wr(cpu_strobe_wr), .cpu_strobe_d(cpu_strobe_d), .cpu_rd(cpu_rd),
`ifdef JOYPAD_TURBO_EN
        .turbo_mask('0),
`endif
        .cpu_rd_data(nf_rd_data), .pad_state(nf_state), .pad_valid(nf_valid));

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked there too.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic capture(input int p, input logic [7:0] d);
        pad_data[8*p +: 8] = d;
        pad_ena[p] = 1'b1;
        cyc();
        pad_ena[p] = 1'b0;
    endtask

    task automatic strobe_pulse();
        cpu_strobe_wr = 1'b1; cpu_strobe_d = 1'b1; cyc();
        cpu_strobe_d = 1'b0; cyc();
        cpu_strobe_wr = 1'b0;
    endtask

    task automatic read_check(input string tag, input int p, input logic exp);
        check(tag, 8'(cpu_rd_data[p]), 8'(exp));
        cpu_rd[p] = 1'b1; cyc();
        cpu_rd[p] = 1'b0;
    endtask

    logic [7:0] exp_bits;
    int ones;

    initial begin
        cyc();
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
        check("rst_valid", 8'(pad_valid), 8'h00);
        check("rst_state", pad_state[7:0], 8'h00);
        check("rst_rd", 8'(cpu_rd_data), 8'h00);

        // Idle pads serialise as eight zeros followed by ones.
        strobe_pulse();
        for (int k = 0; k < 10; k++) read_check($sformatf("idle_rd%0d", k), 0, k >= 8);

        // A+Start, with a read ignored during a strobe write of 0.
        capture(0, 8'h09);
        check("cap_state", pad_state[7:0], 8'h09);
        check("cap_valid", 8'(pad_valid[0]), 8'h01);
        strobe_pulse();
        exp_bits = 8'h09;
        for (int k = 0; k < 3; k++) read_check($sformatf("a_st_rd%0d", k), 0, exp_bits[k]);
        cpu_strobe_wr = 1'b1; cpu_strobe_d = 1'b0; cpu_rd[0] = 1'b1; cyc();
        cpu_strobe_wr = 1'b0; cpu_rd[0] = 1'b0;
        for (int k = 3; k < 8; k++) read_check($sformatf("a_st_rd%0d", k), 0, exp_bits[k]);
        read_check("a_st_rd8", 0, 1'b1);

        // SOCD filtering versus identity.
        capture(0, 8'h3A);
        check("socd_on", pad_state[7:0], 8'h0A);
        check("socd_off", nf_state[7:0], 8'h3A);
        capture(0, 8'hF0);
        check("socd_both", pad_state[7:0], 8'h00);

        // Timeout exactly 100 cycles after capture.
        capture(0, 8'hFF);
        repeat (99) cyc();
        check("to_99_valid", 8'(pad_valid[0]), 8'h01);
        cyc();
        check("to_100_valid", 8'(pad_valid[0]), 8'h00);
        check("to_100_state", pad_state[7:0], 8'h00);
        check("no_to_valid", 8'(nf_valid[0]), 8'h01);

        // Report arriving on the expiry cycle wins and restarts the window.
        capture(0, 8'hFF);
        repeat (99) cyc();
        capture(0, 8'h01);
        check("to_race_valid", 8'(pad_valid[0]), 8'h01);
        check("to_race_state", pad_state[7:0], 8'h01);
        repeat (99) cyc();
        check("to_race_99", 8'(pad_valid[0]), 8'h01);
        cyc();
        check("to_race_100", 8'(pad_valid[0]), 8'h00);

        // Strobe held high: continuous reload, reads do not shift.
        capture(0, 8'h01);
        cpu_strobe_wr = 1'b1; cpu_strobe_d = 1'b1; cyc(); cpu_strobe_wr = 1'b0;
        read_check("hold_rd0", 0, 1'b1);
        capture(0, 8'h02);
        check("hold_lag", 8'(cpu_rd_data[0]), 8'h01);
        cyc();
        read_check("hold_rd1", 0, 1'b0);
        read_check("hold_rd2", 0, 1'b0);
        cpu_strobe_wr = 1'b1; cpu_strobe_d = 1'b0; cyc(); cpu_strobe_wr = 1'b0;

        // Two independent ports, interleaved then simultaneous reads.
        pad_data = {8'h02, 8'h01};
        pad_ena = 2'b11; cyc(); pad_ena = 2'b00;
        strobe_pulse();
        read_check("mp_p0_0", 0, 1'b1);
        read_check("mp_p1_0", 1, 1'b0);
        read_check("mp_p0_1", 0, 1'b0);
        read_check("mp_p1_1", 1, 1'b1);
        check("mp_both", 8'(cpu_rd_data), 8'h00);
        cpu_rd = 2'b11; cyc(); cpu_rd = 2'b00;
        check("mp_after_both", 8'(cpu_rd_data), 8'h00);

        // Reset mid-shift: reads return 0 until the next strobe.
        capture(0, 8'hFF);
        strobe_pulse();
        check("pre_rst_rd", 8'(cpu_rd_data[0]), 8'h01);
        rst = 1'b1; cyc(); rst = 1'b0;
        read_check("post_rst_rd0", 0, 1'b0);
        read_check("post_rst_rd1", 0, 1'b0);
        check("post_rst_valid", 8'(pad_valid), 8'h00);

`ifdef JOYPAD_TURBO_EN
        // Turbo A on pad 0: A toggles with an 8-cycle period while strobed.
        capture(0, 8'h01);
        turbo_mask = 4'b0001;
        cpu_strobe_wr = 1'b1; cpu_strobe_d = 1'b1; cyc(); cpu_strobe_wr = 1'b0;
        cyc();
        ones = 0;
        for (int k = 0; k < 16; k++) begin
            ones += int'(cpu_rd_data[0]);
            cyc();
        end
        check("turbo_duty", 8'(ones), 8'd8);
        check("turbo_state", pad_state[7:0], 8'h01);
        turbo_mask = '0;
        cpu_strobe_wr = 1'b1; cpu_strobe_d = 1'b0; cyc(); cpu_strobe_wr = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/joypad_bridge.md
Name: joypad_bridge

Overview:
Multi-port bridge between USB gamepad report sources and the NES CPU joypad registers ($4016/$4017).
- Captures one 8-bit button report per pad on each report strobe.
- Applies stale-report timeout and optional SOCD filtering.
- Serves the CPU with NES-accurate serial shift registers: strobe latch, 8 reads, then 1s.
- Replaces the direct joypad_cfg/joypad_cfg_upd path into nes_top. Generalises it to NUM_PADS ports with register-level read semantics.

Parameters:
- NUM_PADS, 2, number of controller ports (1..4).
- TIMEOUT_CYCLES, 24'd2400000, cycles without a report before a pad's state is cleared; 0 disables the timeout.
- SOCD_FILTER, 1, 1 = clear both Up and Down when both are set, and clear both Left and Right when both are set.
- TURBO_DIV, 16'd50000, turbo half-period in cycles (used only with JOYPAD_TURBO_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- pad_data  in  8*NUM_PADS  report for pad i at [8i+7:8i]. Bit order: 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
- pad_ena  in  NUM_PADS  one-cycle strobe; the matching pad_data slice is valid.
- cpu_strobe_wr  in  1  one-cycle pulse: CPU write to $4016.
- cpu_strobe_d  in  1  bit 0 of the CPU write data.
- cpu_rd  in  NUM_PADS  one-cycle read pulse for port i.
- cpu_rd_data  out  NUM_PADS  serial bit for port i.
- pad_state  out  8*NUM_PADS  currently held (filtered) button state, for LEDs and debug.
- pad_valid  out  NUM_PADS  1 = a report was received within the timeout window.

Behaviour:
Reset (rst=1 at a clock edge):
- state, shift registers, strobe latch, timeout counters: all 0.
- pad_valid=0, cpu_rd_data=0, pad_state=0.
- Reset asserted mid-shift abandons the sequence. The next CPU read after reset returns 0 until a strobe occurs.

Capture:
- On pad_ena[i]: state[i] <= filt(pad_data[i]), pad_valid[i] <= 1, tcnt[i] <= 0. Visible on pad_state the next cycle.
- filt, with SOCD_FILTER=1: if bits 4 and 5 are both 1, both are cleared; if bits 6 and 7 are both 1, both are cleared. With SOCD_FILTER=0, filt is the identity.

Timeout (TIMEOUT_CYCLES != 0):
- tcnt[i] increments each cycle while pad_valid[i]=1.
- When tcnt[i] reaches TIMEOUT_CYCLES-1: state[i] <= 0, pad_valid[i] <= 0, tcnt[i] <= 0.
- If pad_ena[i] arrives in the same cycle, pad_ena wins: capture proceeds and no clear occurs.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.

Strobe latch:
- On cpu_strobe_wr: strobe <= cpu_strobe_d.

Shift registers, per port, in priority order:
1. If strobe=1, or cpu_strobe_wr=1 with cpu_strobe_d=1: shift[i] <= state[i] every cycle (continuous reload). cpu_rd is ignored for shifting.
2. Else if cpu_strobe_wr=1: no shift; cpu_rd[i] is ignored in this cycle.
3. Else if cpu_rd[i]: shift[i] <= {1'b1, shift[i][7:1]}.

Shift-register timing and boundaries:
- cpu_rd_data[i] = shift[i][0], direct register output.
- The CPU samples cpu_rd_data in the same cycle as cpu_rd. The shift takes effect the next cycle; read-to-next-bit latency is 1 cycle.
- After 8 reads the port returns 1 indefinitely; the 1s shifted in guarantee this.
- pad_ena during strobe=1: the new state appears on shift one cycle after state updates (2 cycles after pad_ena).
- Independent ports: cpu_rd on multiple ports in the same cycle shifts each port independently.

Optional Feature:
JOYPAD_TURBO_EN
- Defined:
  - Adds input turbo_mask (2*NUM_PADS): bit 2i = turbo A, bit 2i+1 = turbo B for pad i.
  - Adds a free-running counter that toggles turbo_phase every TURBO_DIV cycles. Counter and turbo_phase reset to 0.
  - The value loaded into shift[i] has A and/or B forced to 0 when the corresponding mask bit is 1 and turbo_phase=0.
  - pad_state is unaffected by turbo.
- Not defined: no port, no counter; shift loads state unmodified.

Test Plan:
1. Reset, then write strobe 1→0 and issue 10 reads on port 0 → cpu_rd_data[0] = 0,0,0,0,0,0,0,0,1,1.
2. pad_ena[0] with pad_data=8'h09 (A+Start), strobe 1→0, 8 reads → 1,0,0,1,0,0,0,0, then the 9th read returns 1.
3. SOCD_FILTER=1, pad_data=8'h3A → pad_state=8'h0A. SOCD_FILTER=0 → pad_state=8'h3A.
4. TIMEOUT_CYCLES=100: pad_ena with 8'hFF, then idle → pad_valid falls and pad_state=0 exactly 100 cycles after capture. A pad_ena at cycle 99 keeps pad_valid=1.
5. Strobe held 1 with pad_data changing 8'h01→8'h02 and 3 reads → read data follows bit 0 of the current state with no shifting (1, then 0 from 2 cycles after pad_ena).
6. NUM_PADS=2: pad0=8'h01, pad1=8'h02, interleaved reads on ports 0 and 1 → independent streams 1,0,… and 0,1,…. With JOYPAD_TURBO_EN, TURBO_DIV=4 and mask bit 0 set, bit A toggles every 4 cycles while strobe=1.
